// File: rtl/reg32b.sv
// reg32b: WIDTH-bit parallel-load register built from independent per-bit D flip-flop cells.
// Define REG32B_GATE_LEVEL_EN to build each cell as a NAND/NOT master-slave flip-flop.

module reg32b_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);

`ifdef REG32B_GATE_LEVEL_EN
  logic clk_n;
  logic d_n;
  logic force0_n;
  logic force1_n;
  logic m_s_n, m_r_n, m_q, m_qn;
  logic s_s_n, s_r_n, s_q, s_qn;

  // Only one of the two force lines follows res; it pins q to RESET_BIT.
  assign force0_n = RESET_BIT ? 1'b1 : res;
  assign force1_n = RESET_BIT ? res  : 1'b1;

  not u_inv_clk (clk_n, clk);
  not u_inv_d   (d_n, d);

  // Master latch: transparent while clk is low.
  nand u_m_s  (m_s_n, d,     clk_n, force0_n);
  nand u_m_r  (m_r_n, d_n,   clk_n, force1_n);
  nand u_m_q  (m_q,   m_s_n, m_qn,  force1_n);
  nand u_m_qn (m_qn,  m_r_n, m_q,   force0_n);

  // Slave latch: transparent while clk is high, so it takes the master value at the rising edge.
  nand u_s_s  (s_s_n, m_q,   clk,   force0_n);
  nand u_s_r  (s_r_n, m_qn,  clk,   force1_n);
  nand u_s_q  (s_q,   s_s_n, s_qn,  force1_n);
  nand u_s_qn (s_qn,  s_r_n, s_q,   force0_n);

  assign q = s_q;
`else
  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  // NOTE: sequential state uses non-blocking assignments so every cell samples d before any updates.
  always_ff @(posedge clk or negedge res) begin
    if (!res) q_q <= RESET_BIT;
    else      q_q <= q_d;
  end

  assign q = q_q;
`endif

endmodule

module reg32b #(
  parameter int                 WIDTH       = 32,
  parameter logic [0:WIDTH-1]   RESET_VALUE = '0
) (
  output logic [0:WIDTH-1] data_out,
  input  logic [0:WIDTH-1] data_in,
  input  logic             clk,
  input  logic             res
);

  // Bit 0 is the MSB; each cell maps data_in[i] straight to data_out[i].
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg32b_bit_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .res (res),
      .d   (data_in[i]),
      .q   (data_out[i])
    );
  end

endmodule

// File: tb/tb_reg32b.sv
// Self-checking bench for reg32b: scripted timeline scenarios followed by randomized
// capture/hold/reset traffic compared against a word-level reference model.
`timescale 1ns/1ps

module tb_reg32b;

  logic        clk;
  logic        res;
  logic [0:31] data_in;
  logic [0:31] data_out;

  int errors = 0;
  int checks = 0;

  reg32b #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0000_0000)
  ) u_dut (
    .data_out (data_out),
    .data_in  (data_in),
    .clk      (clk),
    .res      (res)
  );

  // Rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic test_powerup;
    wait_until(6.0);
    checks++;
    if (data_out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL powerup_capture: got %h required %h", data_out, 32'h0000_0000);
    end
  endtask

  task automatic test_hold;
    logic [0:31] exp_at [4] = '{32'h0, 32'h2, 32'h2, 32'h4};
    realtime     t_at   [4] = '{12.0, 18.0, 24.0, 26.0};
    data_in = 32'd1;                   // 6 ns update
    for (int k = 0; k < 4; k++) begin
      wait_until(t_at[k]);
      checks++;
      if (data_out !== exp_at[k]) begin
        errors++;
        $display("FAIL hold_t%0t: got %h required %h", $time, data_out, exp_at[k]);
      end
      if (k < 3) data_in = data_in + 32'd1;   // 12, 18, 24 ns updates
    end
    wait_until(30.0);
    data_in = 32'd5;
  endtask

  task automatic test_async_reset;
    wait_until(33.0);
    checks++;
    if (data_out !== 32'h4) begin
      errors++;
      $display("FAIL pre_reset: got %h required %h", data_out, 32'h4);
    end
    wait_until(34.0);
    res = 1'b0;
    #0.5;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", data_out, 32'h0);
    end
  endtask

  task automatic test_reset_dominance;
    for (int k = 0; k < 4; k++) begin
      wait_until(36.0 + 6.0 * k);
      checks++;
      if (data_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_dominance_t%0t: got %h required %h", $time, data_out, 32'h0);
      end
      data_in = 32'd6 + k;
    end
    wait_until(56.0);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_dominance_end: got %h required %h", data_out, 32'h0);
    end
  endtask

  task automatic test_reset_release;
    wait_until(58.0);
    data_in = 32'hA5A5_A5A5;
    res     = 1'b1;
    wait_until(63.0);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL release_hold: got %h required %h", data_out, 32'h0);
    end
    wait_until(66.0);
    checks++;
    if (data_out !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL release_capture: got %h required %h", data_out, 32'hA5A5_A5A5);
    end
    data_in = 32'hFFFF_FFFF;
    wait_until(76.0);
    checks++;
    if (data_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL release_next: got %h required %h", data_out, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_bit_order;
    data_in = 32'h8000_0001;
    wait_until(86.0);
    checks++;
    if (data_out !== 32'h8000_0001) begin
      errors++;
      $display("FAIL bit_order_word: got %h required %h", data_out, 32'h8000_0001);
    end
    checks++;
    if (data_out[0] !== 1'b1 || data_out[31] !== 1'b1 || data_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL bit_order_bits: got b0=%b b1=%b b31=%b required b0=1 b1=0 b31=1",
               data_out[0], data_out[1], data_out[31]);
    end
  endtask

  // Random traffic: each period may pulse reset, may hold it across an edge, and
  // always wiggles data_in between edges; the model only knows "word at edge unless reset".
  task automatic test_random;
    logic [0:31] model;
    logic [0:31] next_word;
    bit          hold_reset;
    model = data_out === 32'h8000_0001 ? 32'h8000_0001 : 32'hDEAD_BEEF;
    model = 32'h8000_0001;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      checks++;
      if (data_out !== model) begin
        errors++;
        $display("FAIL random_hold_%0d: got %h required %h", n, data_out, model);
      end
      data_in    = $urandom;
      hold_reset = 1'b0;
      if ($urandom_range(7) == 0) begin
        res = 1'b0;
        #0.5;
        model = 32'h0;
        checks++;
        if (data_out !== model) begin
          errors++;
          $display("FAIL random_async_%0d: got %h required %h", n, data_out, model);
        end
        hold_reset = ($urandom_range(1) == 1);
        if (!hold_reset) res = 1'b1;
      end
      #1;
      next_word = $urandom;
      data_in   = next_word;
      if (res) model = next_word;
      @(posedge clk);
      #1;
      checks++;
      if (data_out !== model) begin
        errors++;
        $display("FAIL random_capture_%0d: got %h required %h", n, data_out, model);
      end
      data_in = $urandom;
      if (hold_reset) begin
        #1 res = 1'b1;
      end
    end
  endtask

  initial begin
    res     = 1'b1;
    data_in = 32'h0000_0000;
    test_powerup();
    test_hold();
    test_async_reset();
    test_reset_dominance();
    test_reset_release();
    test_bit_order();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg32b.md
Name: reg32b

Overview:
- 32-bit parallel-load storage register built from per-bit D flip-flops.
- Captures the full data word on every rising clock edge; has no load enable.
- Asynchronous active-low reset clears the stored word.
- Generic pipeline or state-holding element in the datapath; a single instance holds one word.

Parameters:
- WIDTH, 32, number of stored bits; the vector range is [0:WIDTH-1], where bit 0 is the MSB and bit WIDTH-1 is the LSB.
- RESET_VALUE, all zeros (WIDTH bits), value forced onto data_out while res is low.

Ports:
- clk  input  1  clock; data captured on the rising edge.
- res  input  1  reset, asynchronous, active-low; 0 clears the register immediately.
- data_out  output  WIDTH  stored word; bit 0 is the MSB.
- data_in  input  WIDTH  word to capture; bit 0 is the MSB.
- Positional port order is fixed: data_out, data_in, clk, res.

Behaviour:
- Structure: WIDTH identical 1-bit D flip-flop cells. Cell i takes data_in[i], clk and res, and drives data_out[i]. No cross-bit logic.
- Capture: on each rising edge of clk with res=1, data_out <= data_in as sampled at that edge. The new value is visible after the edge; latency is 1 clock.
- Hold: between rising edges, data_out is stable. Changes on data_in between edges have no effect. Falling edges have no effect.
- Reset: when res falls to 0, data_out = RESET_VALUE immediately, with no clock required.
  - While res=0, data_out stays at RESET_VALUE and ignores all clock edges and data_in.
- Reset release: when res returns to 1, data_out holds RESET_VALUE until the next rising clk edge, which captures data_in normally.
- Simultaneous events: a rising clk edge coincident with res=0 leaves RESET_VALUE; reset dominates.
- Power-up: there is no initial value. data_out is undefined (X in simulation) until the first rising edge with res=1, or until res is asserted.
- Width rules: data_in and data_out are the same width. There is no arithmetic, truncation or sign handling.
- Ordering: bit-for-bit; data_in[i] maps to data_out[i] and no reversal is permitted.

Optional Feature:
- Macro: REG32B_GATE_LEVEL_EN.
- Defined: each bit cell is built structurally as a positive-edge master-slave D flip-flop.
  - Two gated D latches from NAND/NOT primitives: master transparent when clk=0, slave transparent when clk=1.
  - res gates both latches to force the RESET_VALUE bit asynchronously.
  - Each cell also provides a qn output internally; qn is not exported.
  - Port-level behaviour must match the non-gate-level build exactly once outputs settle.
- Undefined: each bit cell is a behavioural always block sensitive to posedge clk and negedge res.

Test Plan:
1. Power-up capture: res=1, data_in=0x00000000, first rising clk edge at 5 ns -> data_out=0x00000000 after that edge, X before it.
2. Hold between edges: clk period 10 ns (rising at 5, 15, 25 ns); data_in increments by 1 every 6 ns from 0 -> data_out=0x00000000 after the 5 ns edge, 0x00000002 after 15 ns, 0x00000004 after 25 ns. No change at the 6/12/18/24 ns data_in updates.
3. Asynchronous reset mid-period: data_out=0x00000004, res driven 0 at 34 ns (no clk edge at that instant) -> data_out=0x00000000 at 34 ns.
4. Reset dominance: res held 0 across rising edges at 35, 45, 55 ns while data_in keeps incrementing (0x00000005..0x00000009) -> data_out stays 0x00000000 throughout.
5. Reset release: res returns to 1 between edges with data_in=0xA5A5A5A5 -> data_out stays 0x00000000 until the next rising edge, then becomes 0xA5A5A5A5. Next edge with data_in=0xFFFFFFFF -> 0xFFFFFFFF.
6. Bit-order and width check: data_in=0x80000001 (bit 0 and bit 31 set), one rising edge -> data_out=0x80000001 with data_out[0]=1 and data_out[31]=1. Repeat scenarios 1-5 with REG32B_GATE_LEVEL_EN defined -> identical results.
